// File: rtl/fft_pkg.sv
// Shared types and helpers for the in-place radix-2 FFT scheduler.
// The state list depends on FFT_SCHED_BITREV_EN (bit-reversal pre-pass).
package fft_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
`ifdef FFT_SCHED_BITREV_EN
    ST_BR_RD,
    ST_BR_LAT,
    ST_BR_WR,
`endif
    ST_RD,
    ST_LAT,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low 'width' bits of value; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r = (r << 1) | ((value >> i) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational butterfly addressing: (stage, butterfly index) -> top/bottom
// RAM addresses and twiddle ROM index for a radix-2 DIT FFT.
module fft_bfly_addr_gen #(
  parameter int ADDR_WIDTH = 9,
  parameter int STAGE_W    = 5
) (
  input  logic [STAGE_W-1:0]    i_stage,
  input  logic [ADDR_WIDTH-2:0] i_bfly,
  output logic [ADDR_WIDTH-1:0] o_top,
  output logic [ADDR_WIDTH-1:0] o_bot,
  output logic [ADDR_WIDTH-2:0] o_twiddle
);

  localparam logic [ADDR_WIDTH-2:0] ONE_LO = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE    = 1;
  localparam logic [STAGE_W-1:0]    S_ONE  = 1;
  localparam logic [STAGE_W-1:0]    S_MAX  = STAGE_W'(ADDR_WIDTH - 1);

  logic [ADDR_WIDTH-2:0] w_half_lo;
  logic [ADDR_WIDTH-2:0] w_j;
  logic [ADDR_WIDTH-1:0] w_grp;
  logic [STAGE_W-1:0]    w_tw_shift;

  // In the last stage half overflows this width to 0, so the mask becomes
  // all ones and j is the whole butterfly index, which is what we want.
  assign w_half_lo  = ONE_LO << i_stage;
  assign w_j        = i_bfly & (w_half_lo - ONE_LO);
  assign w_grp      = {1'b0, i_bfly} >> i_stage;
  assign o_top      = (w_grp << (i_stage + S_ONE)) | {1'b0, w_j};
  assign o_bot      = o_top | (ONE << i_stage);
  assign w_tw_shift = S_MAX - i_stage;
  assign o_twiddle  = w_j << w_tw_shift;

endmodule

// File: rtl/fft_ram_scheduler.sv
// Sequencer for an in-place radix-2 DIT FFT over a dual-port working RAM.
// Define FFT_SCHED_BITREV_EN to run a bit-reversal pass before stage 0.
module fft_ram_scheduler
  import fft_pkg::*;
#(
  parameter int BUFFER_DEPTH = 512,
  parameter int DATA_WIDTH   = 48,
  parameter int ADDR_WIDTH   = clog2(BUFFER_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [clog2(ADDR_WIDTH):0] o_stage,
  output logic [ADDR_WIDTH-1:0]    o_ram_addr_a,
  output logic [ADDR_WIDTH-1:0]    o_ram_addr_b,
  output logic [DATA_WIDTH-1:0]    o_ram_data_a,
  output logic [DATA_WIDTH-1:0]    o_ram_data_b,
  output logic                     o_ram_wr_en_a,
  output logic                     o_ram_wr_en_b,
  input  logic [DATA_WIDTH-1:0]    i_ram_data_a,
  input  logic [DATA_WIDTH-1:0]    i_ram_data_b,
  output logic                     o_bfly_valid,
  output logic [DATA_WIDTH-1:0]    o_bfly_x,
  output logic [DATA_WIDTH-1:0]    o_bfly_y,
  output logic [ADDR_WIDTH-2:0]    o_bfly_twiddle,
  input  logic                     i_bfly_valid,
  input  logic [DATA_WIDTH-1:0]    i_bfly_x,
  input  logic [DATA_WIDTH-1:0]    i_bfly_y
);

  localparam int STAGE_W = clog2(ADDR_WIDTH) + 1;

  state_t                r_state, w_next;
  logic [STAGE_W-1:0]    r_stage;
  logic [ADDR_WIDTH-2:0] r_bfly;
  logic [DATA_WIDTH-1:0] r_res_x, r_res_y;
  logic [ADDR_WIDTH-1:0] w_top, w_bot;
  logic [ADDR_WIDTH-2:0] w_tw;
  logic                  w_last_bfly, w_last_stage;

  fft_bfly_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .STAGE_W   (STAGE_W)
  ) u_addr_gen (
    .i_stage  (r_stage),
    .i_bfly   (r_bfly),
    .o_top    (w_top),
    .o_bot    (w_bot),
    .o_twiddle(w_tw)
  );

  assign w_last_bfly  = &r_bfly;
  assign w_last_stage = (r_stage == STAGE_W'(ADDR_WIDTH - 1));

`ifdef FFT_SCHED_BITREV_EN
  logic [ADDR_WIDTH-1:0] r_br_idx, w_br_rev;
  logic                  w_br_swap, w_br_last;

  assign w_br_rev  = ADDR_WIDTH'(bitrev(32'(r_br_idx), ADDR_WIDTH));
  assign w_br_swap = (r_br_idx < w_br_rev);
  assign w_br_last = &r_br_idx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage <= '0;
      r_bfly  <= '0;
`ifdef FFT_SCHED_BITREV_EN
      r_br_idx <= '0;
`endif
    end else begin
      case (r_state)
        // Clearing in DONE as well means IDLE is always entered with s=b=0.
        ST_IDLE, ST_DONE: begin
          r_stage <= '0;
          r_bfly  <= '0;
`ifdef FFT_SCHED_BITREV_EN
          r_br_idx <= '0;
`endif
        end
`ifdef FFT_SCHED_BITREV_EN
        ST_BR_RD: if (!w_br_swap) r_br_idx <= r_br_idx + ADDR_WIDTH'(1);
        ST_BR_WR: r_br_idx <= r_br_idx + ADDR_WIDTH'(1);
`endif
        ST_WR: begin
          r_bfly <= r_bfly + (ADDR_WIDTH - 1)'(1);
          if (w_last_bfly) r_stage <= r_stage + STAGE_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result/word holding registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_WAIT && i_bfly_valid) begin
      r_res_x <= i_bfly_x;
      r_res_y <= i_bfly_y;
    end
`ifdef FFT_SCHED_BITREV_EN
    else if (r_state == ST_BR_LAT) begin
      r_res_x <= i_ram_data_a;
      r_res_y <= i_ram_data_b;
    end
`endif
  end

  always_comb begin
    w_next         = r_state;
    o_done         = 1'b0;
    o_ram_addr_a   = '0;
    o_ram_addr_b   = '0;
    o_ram_data_a   = '0;
    o_ram_data_b   = '0;
    o_ram_wr_en_a  = 1'b0;
    o_ram_wr_en_b  = 1'b0;
    o_bfly_valid   = 1'b0;
    o_bfly_x       = '0;
    o_bfly_y       = '0;
    o_bfly_twiddle = '0;
    case (r_state)
      ST_IDLE: begin
`ifdef FFT_SCHED_BITREV_EN
        if (i_start) w_next = ST_BR_RD;
`else
        if (i_start) w_next = ST_RD;
`endif
      end
`ifdef FFT_SCHED_BITREV_EN
      ST_BR_RD: begin
        if (w_br_swap) begin
          o_ram_addr_a = r_br_idx;
          o_ram_addr_b = w_br_rev;
          w_next       = ST_BR_LAT;
        end else if (w_br_last) begin
          w_next = ST_RD;
        end
      end
      ST_BR_LAT: w_next = ST_BR_WR;
      // Port A captured word[i], port B word[r]; write them crossed.
      ST_BR_WR: begin
        o_ram_addr_a  = r_br_idx;
        o_ram_addr_b  = w_br_rev;
        o_ram_data_a  = r_res_y;
        o_ram_data_b  = r_res_x;
        o_ram_wr_en_a = 1'b1;
        o_ram_wr_en_b = 1'b1;
        w_next        = ST_BR_RD;
      end
`endif
      ST_RD: begin
        o_ram_addr_a = w_top;
        o_ram_addr_b = w_bot;
        w_next       = ST_LAT;
      end
      ST_LAT: begin
        o_bfly_valid   = 1'b1;
        o_bfly_x       = i_ram_data_a;
        o_bfly_y       = i_ram_data_b;
        o_bfly_twiddle = w_tw;
        w_next         = ST_WAIT;
      end
      ST_WAIT: if (i_bfly_valid) w_next = ST_WR;
      ST_WR: begin
        o_ram_addr_a  = w_top;
        o_ram_addr_b  = w_bot;
        o_ram_data_a  = r_res_x;
        o_ram_data_b  = r_res_y;
        o_ram_wr_en_a = 1'b1;
        o_ram_wr_en_b = 1'b1;
        w_next        = (w_last_bfly && w_last_stage) ? ST_DONE : ST_RD;
      end
      ST_DONE: begin
        o_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign o_stage = r_stage;

endmodule

// File: tb/tb_fft_ram_scheduler.sv
// Self-checking bench for fft_ram_scheduler (N=8) with a read-first RAM model,
// an x+y / x-y butterfly model and a loop-based reference FFT.
module tb_fft_ram_scheduler;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 48;
  localparam int SW = 3;
  localparam int NB = AW * N / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          i_start = 1'b0;
  logic          o_busy, o_done;
  logic [SW-1:0] o_stage;
  logic [AW-1:0] o_ram_addr_a, o_ram_addr_b;
  logic [DW-1:0] o_ram_data_a, o_ram_data_b;
  logic          o_ram_wr_en_a, o_ram_wr_en_b;
  logic [DW-1:0] ram_q_a, ram_q_b;
  logic          o_bfly_valid;
  logic [DW-1:0] o_bfly_x, o_bfly_y;
  logic [AW-2:0] o_bfly_twiddle;
  logic          bv;
  logic [DW-1:0] bx, by;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  int cnt;
  int br_cyc;

  logic [DW-1:0] mem   [N];
  logic [DW-1:0] img   [N];
  logic [DW-1:0] model [N];
  logic          tb_load = 1'b0;
  int e_top [NB];
  int e_bot [NB];
  int e_tw  [NB];
  int e_stg [NB];

  fft_ram_scheduler #(.BUFFER_DEPTH(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_stage(o_stage),
    .o_ram_addr_a(o_ram_addr_a), .o_ram_addr_b(o_ram_addr_b),
    .o_ram_data_a(o_ram_data_a), .o_ram_data_b(o_ram_data_b),
    .o_ram_wr_en_a(o_ram_wr_en_a), .o_ram_wr_en_b(o_ram_wr_en_b),
    .i_ram_data_a(ram_q_a), .i_ram_data_b(ram_q_b),
    .o_bfly_valid(o_bfly_valid), .o_bfly_x(o_bfly_x), .o_bfly_y(o_bfly_y),
    .o_bfly_twiddle(o_bfly_twiddle),
    .i_bfly_valid(bv), .i_bfly_x(bx), .i_bfly_y(by)
  );

  always #5 clk = ~clk;

  // Read-first dual-port RAM with a bench-side bulk load.
  always @(posedge clk) begin
    ram_q_a <= mem[o_ram_addr_a];
    ram_q_b <= mem[o_ram_addr_b];
    if (tb_load) begin
      for (int k = 0; k < N; k++) mem[k] <= img[k];
    end else begin
      if (o_ram_wr_en_a) mem[o_ram_addr_a] <= o_ram_data_a;
      if (o_ram_wr_en_b) mem[o_ram_addr_b] <= o_ram_data_b;
    end
  end

  // Butterfly unit: result valid exactly 'lat' cycles after operands.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bv  <= 1'b0;
      cnt <= 0;
    end else begin
      bv <= 1'b0;
      if (o_bfly_valid) begin
        bx <= o_bfly_x + o_bfly_y;
        by <= o_bfly_x - o_bfly_y;
        if (lat <= 1) bv <= 1'b1;
        else cnt <= lat - 1;
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) bv <= 1'b1;
      end
    end
  end

  function automatic int brev(input int v);
    int r = 0;
    for (int i = 0; i < AW; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(o_busy), 64'(0));
    chk({tag, "_stage"}, 64'(o_stage), 64'(0));
    chk({tag, "_addr_tw"}, 64'({o_ram_addr_a, o_ram_addr_b, o_bfly_twiddle}), 64'(0));
    chk({tag, "_ctl"}, 64'({o_ram_wr_en_a, o_ram_wr_en_b, o_bfly_valid, o_done}), 64'(0));
    chk({tag, "_data"}, 64'(|{o_ram_data_a, o_ram_data_b, o_bfly_x, o_bfly_y}), 64'(0));
  endtask

  task automatic load_img();
    @(negedge clk); tb_load = 1'b1;
    @(negedge clk); tb_load = 1'b0;
  endtask

  task automatic rand_img();
    for (int k = 0; k < N; k++) img[k] = {16'($urandom), $urandom};
  endtask

  // Reference: optional bit-reverse permutation, then log2(N) stages of
  // (x, y) -> (x+y, x-y) over groups of 2*half with span half.
  task automatic compute_model();
    logic [DW-1:0] x, y;
    for (int k = 0; k < N; k++) model[k] = img[k];
`ifdef FFT_SCHED_BITREV_EN
    for (int k = 0; k < N; k++) model[k] = img[brev(k)];
`endif
    for (int s = 0; s < AW; s++) begin
      for (int g = 0; g < N; g += 2 << s) begin
        for (int j = 0; j < (1 << s); j++) begin
          x = model[g + j];
          y = model[g + j + (1 << s)];
          model[g + j]            = x + y;
          model[g + j + (1 << s)] = x - y;
        end
      end
    end
  endtask

  task automatic run_fft(input int l, input int mid_start);
    int n_lat = 0, first_rd = -1, done_cyc = -1, n_done = 0, n_wr = 0;
    int v_wr = 0, v_port = 0, v_addr = 0, v_op = 0, v_br = 0, v_fixed = 0;
    logic [AW-1:0] prev_a = '0, prev_b = '0, last_a = '0, last_b = '0;
    bit res_ok = 0;
    lat = l;
    compute_model();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_start = (cyc == mid_start);
      if (cyc == 0) chk("busy_first_cycle", 64'(o_busy), 64'(1));
      if (o_bfly_valid) begin
        if (n_lat == 0) begin
          first_rd = cyc - 1;
          for (int k = 0; k < N; k++) if (mem[k] !== img[brev(k)]) v_br++;
        end
        if (n_lat < NB) begin
          chk($sformatf("rd_top%0d", n_lat), 64'(prev_a), 64'(e_top[n_lat]));
          chk($sformatf("rd_bot%0d", n_lat), 64'(prev_b), 64'(e_bot[n_lat]));
          chk($sformatf("twiddle%0d", n_lat), 64'(o_bfly_twiddle), 64'(e_tw[n_lat]));
          chk($sformatf("stage%0d", n_lat), 64'(o_stage), 64'(e_stg[n_lat]));
        end
        if (o_bfly_x !== mem[prev_a] || o_bfly_y !== mem[prev_b]) v_op++;
        last_a = prev_a; last_b = prev_b;
        res_ok = 0;
        n_lat++;
      end
      if (bv) res_ok = 1;
      if (o_ram_wr_en_a || o_ram_wr_en_b) begin
        if (o_ram_addr_a == o_ram_addr_b) v_port++;
        if (n_lat > 0) begin
          if (!res_ok) v_wr++;
          if (o_ram_addr_a != last_a || o_ram_addr_b != last_b) v_addr++;
          res_ok = 0;
          n_wr++;
        end else begin
          if (brev(int'(o_ram_addr_a)) == int'(o_ram_addr_a)) v_fixed++;
          if (brev(int'(o_ram_addr_b)) == int'(o_ram_addr_b)) v_fixed++;
        end
      end
      if (o_done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("busy_at_done", 64'(o_busy), 64'(0));
        end
      end
      prev_a = o_ram_addr_a; prev_b = o_ram_addr_b;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    i_start = 1'b0;
    chk("done_seen", 64'(done_cyc >= 0), 64'(1));
    chk("bfly_count", 64'(n_lat), 64'(NB));
    chk("fft_writes", 64'(n_wr), 64'(NB));
    chk("first_rd_cycle", 64'(first_rd), 64'(br_cyc));
    chk("total_cycles", 64'(done_cyc - first_rd), 64'(NB * (3 + l)));
    chk("single_done", 64'(n_done), 64'(1));
    chk("wr_before_result", 64'(v_wr), 64'(0));
    chk("port_collision", 64'(v_port), 64'(0));
    chk("wr_addr_vs_rd", 64'(v_addr), 64'(0));
    chk("operand_passthru", 64'(v_op), 64'(0));
`ifdef FFT_SCHED_BITREV_EN
    chk("bitrev_perm", 64'(v_br), 64'(0));
    chk("bitrev_fixed_wr", 64'(v_fixed), 64'(0));
`endif
    for (int k = 0; k < N; k++) chk($sformatf("ram%0d", k), 64'(mem[k]), 64'(model[k]));
    chk("idle_stage", 64'(o_stage), 64'(0));
    chk("idle_busy", 64'(o_busy), 64'(0));
  endtask

  initial begin
    int idx = 0;
    bit found = 0;
    for (int s = 0; s < AW; s++) begin
      for (int g = 0; g < N / (2 << s); g++) begin
        for (int j = 0; j < (1 << s); j++) begin
          e_top[idx] = g * (2 << s) + j;
          e_bot[idx] = e_top[idx] + (1 << s);
          e_tw[idx]  = j * (N / (2 << s));
          e_stg[idx] = s;
          idx++;
        end
      end
    end
    br_cyc = 0;
`ifdef FFT_SCHED_BITREV_EN
    for (int i = 0; i < N; i++) br_cyc += (i < brev(i)) ? 3 : 1;
`endif

    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 64'(o_busy), 64'(0));

    for (int k = 0; k < N; k++) img[k] = 48'd1;
    load_img();
    run_fft(1, -1);
    chk("ones_ram0", 64'(mem[0]), 64'(8));

    rand_img(); load_img();
    run_fft(3, -1);

    rand_img(); load_img();
    run_fft(2, br_cyc + 25);

    rand_img(); load_img();
    lat = 3;
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (o_bfly_valid && o_stage == 1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("midrst_reached_stage1", 64'(found), 64'(1));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b1;

    rand_img(); load_img();
    run_fft(1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
